int_sequencer: RTL and testbench



---
 rtl/int_sequencer_pkg.sv | 38 +++
 rtl/int_sequencer_sync.sv | 34 +++
 rtl/int_sequencer.sv | 144 ++++++++++++++
 tb/tb_int_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// int_sequencer shared definitions: request sources, vector bytes,
// and the step numbers of the interrupt entry sequence.
package int_sequencer_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SEQ
  } state_e;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2
  } src_e;

  localparam logic [7:0] VEC_RST = 8'hFC;
  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  localparam logic [2:0] STEP_BRK        = 3'd0;
  localparam logic [2:0] STEP_PUSH_FIRST = 3'd2;
  localparam logic [2:0] STEP_PUSH_LAST  = 3'd4;
  localparam logic [2:0] STEP_VEC_FIRST  = 3'd5;
  localparam logic [2:0] STEP_LAST       = 3'd6;

  function automatic logic [7:0] vec_of(src_e s);
    logic [7:0] v;
    v = 8'h00;
    unique case (s)
      SRC_RST: v = VEC_RST;
      SRC_NMI: v = VEC_NMI;
      SRC_IRQ: v = VEC_IRQ;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_sequencer_sync.sv
// Multi-flop synchronizer for one async request line; optionally
// reports the 0->1 transition of the synchronized level instead.
module int_sync #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_out
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= w_level;
    end
  end

  assign o_out = EDGE ? (w_level & ~r_prev) : w_level;

endmodule

// File: rtl/int_sequencer.sv
// 6502 reset/NMI/IRQ arbiter and 7-step entry sequencer
// (BRK inject, three pushes, two vector fetches).
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SEQ_LEN     = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       irq,
  input  logic       nmi,
  input  logic       sync,
  input  logic       iflag,
  output logic       seq_busy,
  output logic [2:0] step,
  output logic       force_brk,
  output logic       push_en,
  output logic       force_read,
  output logic       setreset,
  output logic       setnmi,
  output logic       setirq,
  output logic [7:0] vec_lo,
  output logic       set_i,
  output logic       b_out
);

  if (SEQ_LEN != 7) begin : g_bad_len
    $error("int_sequencer: SEQ_LEN must be 7");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("int_sequencer: SYNC_STAGES must be 1..3");
  end

  state_e     r_state, w_state_n;
  src_e       r_src, w_src_n;
  logic [2:0] r_step, w_step_n;
  logic       r_rst_pend, w_rst_pend_n;
  logic       r_nmi_pend, w_nmi_pend_n;
  logic       w_nmi_clr;
  logic       w_nmi_rise;
  logic       w_irq_lvl;
  logic       w_irq_req;

  int_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_nmi_sync (
    .clk     (clk),
    .rst_n   (clr),
    .i_async (nmi),
    .o_out   (w_nmi_rise)
  );

  int_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_irq_sync (
    .clk     (clk),
    .rst_n   (clr),
    .i_async (irq),
    .o_out   (w_irq_lvl)
  );

  assign w_irq_req = w_irq_lvl & ~iflag;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= ST_IDLE;
      r_src      <= SRC_RST;
      r_step     <= 3'd0;
      r_rst_pend <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_src      <= w_src_n;
      r_step     <= w_step_n;
      r_rst_pend <= w_rst_pend_n;
      r_nmi_pend <= w_nmi_pend_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_src_n      = r_src;
    w_step_n     = r_step;
    w_rst_pend_n = r_rst_pend;
    w_nmi_clr    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_step_n = 3'd0;
        if (r_rst_pend) begin
          w_state_n    = ST_SEQ;
          w_src_n      = SRC_RST;
          w_rst_pend_n = 1'b0;
        end else if (sync && r_nmi_pend) begin
          w_state_n = ST_SEQ;
          w_src_n   = SRC_NMI;
        end else if (sync && w_irq_req) begin
          w_state_n = ST_SEQ;
          w_src_n   = SRC_IRQ;
        end
      end
      ST_SEQ: begin
        if (r_step == STEP_LAST) begin
          w_state_n = ST_IDLE;
          w_step_n  = 3'd0;
        end else begin
          w_step_n = r_step + 3'd1;
          // vector commit: a pending NMI steals an IRQ entry here
          if (w_step_n == STEP_VEC_FIRST) begin
            if (r_src == SRC_IRQ && r_nmi_pend) begin
              w_src_n   = SRC_NMI;
              w_nmi_clr = 1'b1;
            end else if (r_src == SRC_NMI) begin
              w_nmi_clr = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_step_n  = 3'd0;
      end
    endcase
    w_nmi_pend_n = (r_nmi_pend & ~w_nmi_clr) | w_nmi_rise;
  end

  logic w_busy;
  logic w_push_win;
  logic w_vec_win;

  assign w_busy     = (r_state == ST_SEQ);
  assign w_push_win = w_busy && r_step >= STEP_PUSH_FIRST
                      && r_step <= STEP_PUSH_LAST;
  assign w_vec_win  = w_busy && r_step >= STEP_VEC_FIRST;

  assign seq_busy   = w_busy;
  assign step       = r_step;
  assign force_brk  = w_busy && r_step == STEP_BRK;
  assign push_en    = w_push_win && r_src != SRC_RST;
  assign force_read = w_push_win && r_src == SRC_RST;
  assign setreset   = w_vec_win && r_src == SRC_RST;
  assign setnmi     = w_vec_win && r_src == SRC_NMI;
  assign setirq     = w_vec_win && r_src == SRC_IRQ;
  assign vec_lo     = w_vec_win ? vec_of(r_src) : 8'h00;
  assign set_i      = w_busy && r_step == STEP_VEC_FIRST;
  assign b_out      = 1'b0;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed + random bench for int_sequencer against a cycle-indexed
// behavioural model of the arbitration rules.
module tb_int_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       irq = 1'b0;
  logic       nmi = 1'b0;
  logic       sync = 1'b0;
  logic       iflag = 1'b0;
  logic       seq_busy;
  logic [2:0] step;
  logic       force_brk;
  logic       push_en;
  logic       force_read;
  logic       setreset;
  logic       setnmi;
  logic       setirq;
  logic [7:0] vec_lo;
  logic       set_i;
  logic       b_out;

  int_sequencer #(.SYNC_STAGES(S), .SEQ_LEN(7)) dut (
    .clk        (clk),
    .clr        (clr),
    .irq        (irq),
    .nmi        (nmi),
    .sync       (sync),
    .iflag      (iflag),
    .seq_busy   (seq_busy),
    .step       (step),
    .force_brk  (force_brk),
    .push_en    (push_en),
    .force_read (force_read),
    .setreset   (setreset),
    .setnmi     (setnmi),
    .setirq     (setirq),
    .vec_lo     (vec_lo),
    .set_i      (set_i),
    .b_out      (b_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: 0=reset, 1=nmi, 2=irq
  bit m_busy;
  int m_st;
  int m_src;
  bit m_nmi_pend;
  bit m_rst_pend;
  bit nh [0:4];
  bit ih [0:4];

  // window statistics
  int w_starts, w_push, w_fread, w_seti;
  logic [7:0] w_vec;
  logic [2:0] w_sel;

  function automatic logic [19:0] obs_vec();
    return {seq_busy, step, force_brk, push_en, force_read,
            setreset, setnmi, setirq, vec_lo, set_i, b_out};
  endfunction

  function automatic logic [19:0] exp_vec();
    bit push, vec;
    logic [7:0] v;
    logic [2:0] st;
    push = m_busy && m_st >= 2 && m_st <= 4;
    vec  = m_busy && m_st >= 5;
    v    = 8'h00;
    if (vec) v = (m_src == 0) ? 8'hFC : (m_src == 1) ? 8'hFA : 8'hFE;
    st = m_busy ? 3'(m_st) : 3'd0;
    return {m_busy, st, m_busy && m_st == 0,
            push && m_src != 0, push && m_src == 0,
            vec && m_src == 0, vec && m_src == 1, vec && m_src == 2,
            v, m_busy && m_st == 5, 1'b0};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_st = 0; m_src = 0;
    m_nmi_pend = 0; m_rst_pend = 1;
    for (int k = 0; k < 5; k++) begin
      nh[k] = 0; ih[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit rise, ivis, clear;
    if (!clr) begin
      model_reset();
      return;
    end
    rise = nh[S-1] && !nh[S];
    ivis = ih[S-1];
    for (int k = 4; k > 0; k--) begin
      nh[k] = nh[k-1]; ih[k] = ih[k-1];
    end
    nh[0] = nmi; ih[0] = irq;
    clear = 0;
    if (!m_busy) begin
      if (m_rst_pend) begin
        m_busy = 1; m_st = 0; m_src = 0; m_rst_pend = 0;
      end else if (sync && m_nmi_pend) begin
        m_busy = 1; m_st = 0; m_src = 1;
      end else if (sync && ivis && !iflag) begin
        m_busy = 1; m_st = 0; m_src = 2;
      end
    end else if (m_st == 6) begin
      m_busy = 0; m_st = 0;
    end else begin
      m_st++;
      if (m_st == 5) begin
        if (m_src == 2 && m_nmi_pend) m_src = 1;
        if (m_src == 1) clear = 1;
      end
    end
    m_nmi_pend = (m_nmi_pend && !clear) || rise;
  endtask

  task automatic check_cycle(string tag);
    logic [19:0] o, e;
    o = obs_vec();
    e = exp_vec();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, o, e);
    end
  endtask

  task automatic chk(string tag, int got, int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_cycle("cyc");
    if (force_brk) w_starts++;
    if (push_en) w_push++;
    if (force_read) w_fread++;
    if (set_i) begin
      w_seti++;
      w_vec = vec_lo;
      w_sel = {setreset, setnmi, setirq};
    end
  endtask

  task automatic win_clear();
    w_starts = 0; w_push = 0; w_fread = 0; w_seti = 0;
    w_vec = 8'h00; w_sel = 3'b000;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic wait_step(int s, int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (seq_busy && step == 3'(s)) begin
        ok = 1;
        break;
      end
    end
    chk("wait_step", int'(ok), 1);
  endtask

  initial begin
    model_reset();
    win_clear();
    #1;
    check_cycle("reset");
    @(negedge clk);
    clr = 1'b1;

    win_clear();
    ticks(9);
    chk("rst_starts", w_starts, 1);
    chk("rst_fread", w_fread, 3);
    chk("rst_push", w_push, 0);
    chk("rst_seti", w_seti, 1);
    chk("rst_vec", int'(w_vec), 'hFC);
    chk("rst_idle", int'(seq_busy), 0);

    irq = 1'b1;
    ticks(3);
    win_clear();
    sync_pulse();
    ticks(9);
    chk("irq_starts", w_starts, 1);
    chk("irq_push", w_push, 3);
    chk("irq_vec", int'(w_vec), 'hFE);
    chk("irq_sel", int'(w_sel), 1);
    iflag = 1'b1;
    win_clear();
    sync_pulse();
    ticks(9);
    chk("irq_masked", w_starts, 0);
    irq = 1'b0;
    iflag = 1'b0;
    ticks(4);

    nmi = 1'b1;
    ticks(2);
    nmi = 1'b0;
    ticks(5);
    win_clear();
    sync_pulse();
    ticks(9);
    chk("nmi_starts", w_starts, 1);
    chk("nmi_vec", int'(w_vec), 'hFA);
    chk("nmi_sel", int'(w_sel), 2);

    nmi = 1'b1;
    ticks(5);
    win_clear();
    for (int i = 0; i < 8; i++) begin
      sync_pulse();
      ticks(2);
    end
    chk("nmi_held", w_starts, 1);
    nmi = 1'b0;
    ticks(4);

    irq = 1'b1;
    ticks(3);
    win_clear();
    sync_pulse();
    irq = 1'b0;
    wait_step(1, 8);
    nmi = 1'b1;
    ticks(8);
    chk("hijack_vec", int'(w_vec), 'hFA);
    chk("hijack_sel", int'(w_sel), 2);
    chk("hijack_push", w_push, 3);
    nmi = 1'b0;
    ticks(4);

    irq = 1'b1;
    ticks(3);
    win_clear();
    sync_pulse();
    irq = 1'b0;
    wait_step(4, 8);
    nmi = 1'b1;
    ticks(6);
    chk("late_vec", int'(w_vec), 'hFE);
    win_clear();
    sync_pulse();
    ticks(8);
    chk("late_nmi_vec", int'(w_vec), 'hFA);
    chk("late_nmi_starts", w_starts, 1);
    nmi = 1'b0;
    ticks(4);

    irq = 1'b1;
    nmi = 1'b1;
    ticks(4);
    win_clear();
    sync_pulse();
    iflag = 1'b1;
    ticks(8);
    chk("both_first", int'(w_vec), 'hFA);
    iflag = 1'b0;
    win_clear();
    sync_pulse();
    ticks(8);
    chk("both_second", int'(w_vec), 'hFE);
    irq = 1'b0;
    nmi = 1'b0;
    ticks(4);

    irq = 1'b1;
    ticks(3);
    sync_pulse();
    wait_step(3, 8);
    clr = 1'b0;
    #1;
    model_reset();
    check_cycle("clr_async");
    chk("clr_push", int'(push_en), 0);
    ticks(2);
    clr = 1'b1;
    irq = 1'b0;
    win_clear();
    ticks(9);
    chk("clr_rst_vec", int'(w_vec), 'hFC);
    chk("clr_rst_sel", int'(w_sel), 4);

    for (int i = 0; i < 400; i++) begin
      irq   = ($urandom_range(0, 3) == 0);
      nmi   = ($urandom_range(0, 5) == 0) ? ~nmi : nmi;
      sync  = ($urandom_range(0, 3) == 0);
      iflag = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
